// File: rtl/instr_encoder.sv
// instr_encoder: packs R/I-type fields into RV32I words and streams them to IMEM through a small FIFO.
// Optional macro ENC_NOP_PAD_EN pads each session with NOPs up to a multiple of four words.
`default_nettype none

module instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int IMEM_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        type_i,
  input  logic [6:0]  funct7_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [11:0] imm_i,
  input  logic        last_i,
  output logic        mem_we_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        wrap_o,
  output logic [15:0] count_o
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] ADDR_LAST = 32'(IMEM_WORDS * 4 - 4);
  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_I      = 7'b0010011;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        active;
  logic        pad_pending;
  logic        word_valid;
  logic [31:0] enc_word;
  logic [31:0] out_word;
  logic [31:0] addr;
  logic [15:0] count;
  logic        wrap;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign active     = (state == LOAD) || (state == DRAIN);

  always_comb begin
    enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
    if (type_i) begin
      enc_word = {imm_i, rs1_i, funct3_i, rd_i, OP_I};
    end
  end

`ifdef ENC_NOP_PAD_EN
  // Once the buffer drains, keep issuing NOPs until the word count is a multiple of four.
  assign pad_pending = (count[1:0] != 2'd0);
  assign word_valid  = !fifo_empty || ((state == DRAIN) && pad_pending);
  assign out_word    = fifo_empty ? NOP_WORD : fifo_mem[rd_ptr[AW-1:0]];
`else
  assign pad_pending = 1'b0;
  assign word_valid  = !fifo_empty;
  assign out_word    = fifo_mem[rd_ptr[AW-1:0]];
`endif

  // No pass-through: a full FIFO refuses requests even while a pop is in flight.
  assign req_ready_o = (state == LOAD) && !fifo_full;
  assign push        = req_valid_i && req_ready_o;
  assign mem_we_o    = active && word_valid;
  assign pop         = mem_we_o && mem_ready_i;
  assign mem_data_o  = mem_we_o ? out_word : 32'd0;
  assign mem_addr_o  = addr;
  assign count_o     = count;
  assign wrap_o      = wrap;
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= enc_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !fifo_empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr  <= 32'd0;
      count <= 16'd0;
      wrap  <= 1'b0;
    end else if ((state == IDLE) && start_i) begin
      addr  <= 32'd0;
      count <= 16'd0;
      wrap  <= 1'b0;
    end else if (pop) begin
      count <= count + 16'd1;
      if (addr == ADDR_LAST) begin
        addr <= 32'd0;
        wrap <= 1'b1;
      end else begin
        addr <= addr + 32'd4;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = LOAD;
      LOAD:    if (push && last_i) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty && !pad_pending) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table of encodings plus handshake, wrap and reset sequences.
`default_nettype none

module tb_instr_encoder;

`ifdef ENC_NOP_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        typ;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_w = 1'b1;
  logic        start = 1'b0;
  logic        req_valid = 1'b0;
  logic        typ = 1'b0;
  logic [6:0]  f7 = '0;
  logic [2:0]  f3 = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [11:0] imm = '0;
  logic        last = 1'b0;
  logic        mem_ready = 1'b0;

  logic        req_ready, mem_we, busy, done, wrap;
  logic [31:0] mem_addr, mem_data;
  logic [15:0] count;
  logic        w_req_ready, w_mem_we, w_busy, w_done, w_wrap;
  logic [31:0] w_mem_addr, w_mem_data;
  logic [15:0] w_count;

  int nvec = 0;
  int nerr = 0;
  vec_t vt[8];
  logic [31:0] exp_a[$], exp_d[$];
  logic [31:0] got_a[$], got_d[$], gw_a[$], gw_d[$];

  always #5 clk = ~clk;

  instr_encoder #(.FIFO_DEPTH(4), .IMEM_WORDS(256)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .type_i(typ), .funct7_i(f7), .funct3_i(f3), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .last_i(last), .mem_we_o(mem_we), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .busy_o(busy), .done_o(done), .wrap_o(wrap), .count_o(count)
  );

  instr_encoder #(.FIFO_DEPTH(4), .IMEM_WORDS(4)) dut_w (
    .clk_i(clk), .rst_i(rst_w), .start_i(start), .req_valid_i(req_valid), .req_ready_o(w_req_ready),
    .type_i(typ), .funct7_i(f7), .funct3_i(f3), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .last_i(last), .mem_we_o(w_mem_we), .mem_ready_i(mem_ready), .mem_addr_o(w_mem_addr),
    .mem_data_o(w_mem_data), .busy_o(w_busy), .done_o(w_done), .wrap_o(w_wrap), .count_o(w_count)
  );

  // Record every accepted IMEM write (the pop happens at the following rising edge).
  always @(negedge clk) begin
    if (mem_we && mem_ready) begin
      got_a.push_back(mem_addr);
      got_d.push_back(mem_data);
    end
    if (w_mem_we && mem_ready) begin
      gw_a.push_back(w_mem_addr);
      gw_d.push_back(w_mem_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drive(input vec_t v, input logic is_last);
    typ = v.typ; f7 = v.f7; f3 = v.f3; rd = v.rd;
    rs1 = v.rs1; rs2 = v.rs2; imm = v.imm; last = is_last;
    req_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk({name, "_accept_timeout"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic push_req(input vec_t v, input logic is_last, input string name);
    drive(v, is_last);
    wait_accept(name);
  endtask

  task automatic wait_done(input string name, input bit use_w);
    int n = 0;
    @(negedge clk);
    while (!(use_w ? w_done : done) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, 32'(use_w ? w_done : done), 32'd1);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, 32'(use_w ? w_done : done), 32'd0);
    chk({name, "_idle"}, 32'(use_w ? w_busy : busy), 32'd0);
  endtask

  task automatic clear_q();
    exp_a.delete(); exp_d.delete();
    got_a.delete(); got_d.delete();
    gw_a.delete(); gw_d.delete();
  endtask

  task automatic expect_pad(input int modw);
    if (PAD) begin
      while (exp_d.size() % 4 != 0) begin
        exp_a.push_back(32'((exp_d.size() * 4) % modw));
        exp_d.push_back(NOP);
      end
    end
  endtask

  task automatic compare_q(input string name, input bit use_w);
    int ng;
    ng = use_w ? gw_d.size() : got_d.size();
    chk({name, "_nwrites"}, 32'(ng), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < ng; i++) begin
      chk($sformatf("%s_data%0d", name, i), use_w ? gw_d[i] : got_d[i], exp_d[i]);
      chk($sformatf("%s_addr%0d", name, i), use_w ? gw_a[i] : got_a[i], exp_a[i]);
    end
  endtask

  initial begin
    //        typ   f7      f3    rd     rs1    rs2    imm       expected word
    vt[0] = '{1'b0, 7'h00, 3'd0, 5'd3,  5'd1,  5'd2,  12'h000, 32'h002081B3}; // add x3,x1,x2
    vt[1] = '{1'b1, 7'h00, 3'd0, 5'd5,  5'd0,  5'd0,  12'hFFF, 32'hFFF00293}; // addi x5,x0,-1
    vt[2] = '{1'b0, 7'h20, 3'd0, 5'd10, 5'd11, 5'd12, 12'h000, 32'h40C58533}; // sub x10,x11,x12
    vt[3] = '{1'b1, 7'h00, 3'd7, 5'd31, 5'd31, 5'd0,  12'h7FF, 32'h7FFFFF93}; // andi x31,x31,0x7ff
    vt[4] = '{1'b0, 7'h00, 3'd4, 5'd0,  5'd0,  5'd0,  12'h000, 32'h00004033}; // xor x0,x0,x0
    vt[5] = '{1'b1, 7'h7F, 3'd1, 5'd1,  5'd2,  5'd31, 12'h005, 32'h00511093}; // slli, rs2/f7 ignored
    vt[6] = '{1'b0, 7'h00, 3'd6, 5'd7,  5'd8,  5'd9,  12'hABC, 32'h009463B3}; // or, imm ignored
    vt[7] = '{1'b0, 7'h7F, 3'd0, 5'd0,  5'd0,  5'd0,  12'h000, 32'hFE000033};

    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_data", mem_data, 32'd0);

    // Single R-type write
    clear_q();
    mem_ready = 1'b1;
    start_session();
    push_req(vt[0], 1'b1, "single");
    wait_done("single", 1'b0);
    exp_d.push_back(vt[0].exp); exp_a.push_back(32'd0);
    expect_pad(1024);
    compare_q("single", 1'b0);
    chk("single_count", 32'(count), 32'(exp_d.size()));

    // Full table in one session; a stray start mid-session must be ignored
    clear_q();
    start_session();
    for (int i = 0; i < 8; i++) begin
      push_req(vt[i], i == 7, $sformatf("tbl%0d", i));
      if (i == 2) begin
        start = 1'b1;
        step();
        start = 1'b0;
      end
      exp_d.push_back(vt[i].exp);
      exp_a.push_back(32'(i * 4));
    end
    wait_done("tbl", 1'b0);
    compare_q("tbl", 1'b0);
    chk("tbl_count", 32'(count), 32'd8);

    // Backpressure: FIFO fills at 4, head stays put, fifth is refused until space frees
    clear_q();
    mem_ready = 1'b0;
    start_session();
    for (int i = 1; i <= 4; i++) push_req(vt[i], 1'b0, $sformatf("bp%0d", i));
    drive(vt[5], 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp_full_ready%0d", c), 32'(req_ready), 32'd0);
      chk($sformatf("bp_we%0d", c), 32'(mem_we), 32'd1);
      chk($sformatf("bp_head%0d", c), mem_data, vt[1].exp);
      chk($sformatf("bp_addr%0d", c), mem_addr, 32'd0);
    end
    step();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_passthru", 32'(req_ready), 32'd0);
    wait_accept("bp5");
    wait_done("bp", 1'b0);
    for (int i = 1; i <= 5; i++) begin
      exp_d.push_back(vt[i].exp);
      exp_a.push_back(32'((i - 1) * 4));
    end
    expect_pad(1024);
    compare_q("bp", 1'b0);
    chk("bp_count", 32'(count), 32'(exp_d.size()));
    chk("bp_nowrap", 32'(wrap), 32'd0);

    // Wrap in a 4-word IMEM
    clear_q();
    rst_w = 1'b0;
    step();
    start_session();
    for (int i = 0; i < 6; i++) begin
      push_req(vt[i], i == 5, $sformatf("wrap%0d", i));
      exp_d.push_back(vt[i].exp);
      exp_a.push_back(32'((i * 4) % 16));
    end
    wait_done("wrap", 1'b1);
    expect_pad(16);
    compare_q("wrap", 1'b1);
    chk("wrap_flag", 32'(w_wrap), 32'd1);
    chk("wrap_count", 32'(w_count), 32'(exp_d.size()));
    chk("wrap_big_noflag", 32'(wrap), 32'd0);
    rst_w = 1'b1;
    step();

    // Reset mid-session with three words buffered
    clear_q();
    start_session();
    push_req(vt[0], 1'b0, "rstm0");
    repeat (3) step();
    mem_ready = 1'b0;
    for (int i = 2; i <= 4; i++) push_req(vt[i], 1'b0, $sformatf("rstm%0d", i));
    chk("rstm_precount", 32'(count), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstm_we", 32'(mem_we), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_count", 32'(count), 32'd0);
    chk("rstm_addr", mem_addr, 32'd0);
    got_a.delete(); got_d.delete();
    step();
    mem_ready = 1'b1;
    repeat (10) step();
    chk("rstm_no_writes", 32'(got_d.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
